// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: client request/grant/return signals plus the RAM pin bundle
// that the arbiter drives and listens to.
interface ram_port_arbiter_if #(
    parameter int DW = 4,
    parameter int AW = 5
);
    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_w;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_w, mem_addr, mem_din
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_w, mem_addr, mem_din
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-port round-robin arbiter that registers the winning command
// onto a single-port RAM and tags the registered read data back to its requester.
module ram_port_arbiter #(
    parameter int DW = 4,
    parameter int AW = 5
) (
    input logic              clk,
    input logic              rst_n,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {TAG_NONE, TAG_RD0, TAG_RD1} tag_e;

    logic          last_q, last_d;
    logic          mem_w_q, mem_w_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    tag_e          tag1_q, tag1_d, tag2_q, tag2_d;
    logic          xfer, sel, we_sel;

    // Contention goes to the port that was not granted last.
    assign bus.gnt0 = bus.req0 & (~bus.req1 | last_q);
    assign bus.gnt1 = bus.req1 & (~bus.req0 | ~last_q);
    assign xfer     = bus.gnt0 | bus.gnt1;
    assign sel      = bus.gnt1;
    assign we_sel   = sel ? bus.we1 : bus.we0;

    always_comb begin
        last_d  = xfer ? sel : last_q;
        mem_w_d = xfer & we_sel;
        addr_d  = xfer ? (sel ? bus.addr1 : bus.addr0) : addr_q;
        din_d   = xfer ? (sel ? bus.wdata1 : bus.wdata0) : din_q;
        tag1_d  = (!xfer || we_sel) ? TAG_NONE : (sel ? TAG_RD1 : TAG_RD0);
        tag2_d  = tag1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b0;
            mem_w_q <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            tag1_q  <= TAG_NONE;
            tag2_q  <= TAG_NONE;
        end else begin
            last_q  <= last_d;
            mem_w_q <= mem_w_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag2_d;
        end
    end

    assign bus.mem_w    = mem_w_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;
    assign bus.rvalid0  = (tag2_q == TAG_RD0);
    assign bus.rvalid1  = (tag2_q == TAG_RD1);
    assign bus.rdata0   = bus.mem_dout;
    assign bus.rdata1   = bus.mem_dout;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed cycle vectors against the arbiter driving a
// registered-read 32x4 RAM model, plus a hand-written mid-read reset sequence.
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [3:0] mem [32];

    ram_port_arbiter_if #(.DW(4), .AW(5)) bus ();
    ram_port_arbiter #(.DW(4), .AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_w) mem[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= mem[bus.mem_addr];
    end

    typedef struct {
        logic r0, r1, w0, w1;
        logic [4:0] a0, a1;
        logic [3:0] d0, d1;
        logic g0, g1, mw;
        logic [4:0] ma;
        logic [3:0] md;
        logic v0, v1;
        logic [3:0] rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r0, logic r1, logic w0, logic w1,
                                logic [4:0] a0, logic [4:0] a1, logic [3:0] d0, logic [3:0] d1,
                                logic g0, logic g1, logic mw, logic [4:0] ma, logic [3:0] md,
                                logic v0, logic v1, logic [3:0] rd);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.mw = mw; v.ma = ma; v.md = md;
        v.v0 = v0; v.v1 = v1; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.req0 = v.r0; bus.req1 = v.r1; bus.we0 = v.w0; bus.we1 = v.w1;
        bus.addr0 = v.a0; bus.addr1 = v.a1; bus.wdata0 = v.d0; bus.wdata1 = v.d1;
    endtask

    task automatic step(input vec_t v, input int idx);
        drive(v);
        #1;
        chk("gnt0", idx, int'(bus.gnt0), int'(v.g0));
        chk("gnt1", idx, int'(bus.gnt1), int'(v.g1));
        @(posedge clk);
        #1;
        chk("mem_w", idx, int'(bus.mem_w), int'(v.mw));
        chk("mem_addr", idx, int'(bus.mem_addr), int'(v.ma));
        chk("mem_din", idx, int'(bus.mem_din), int'(v.md));
        chk("rvalid0", idx, int'(bus.rvalid0), int'(v.v0));
        chk("rvalid1", idx, int'(bus.rvalid1), int'(v.v1));
        if (v.v0) chk("rdata0", idx, int'(bus.rdata0), int'(v.rd));
        if (v.v1) chk("rdata1", idx, int'(bus.rdata1), int'(v.rd));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 4'(i);
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        // single client write then read of addr 5, then idle
        tbl.push_back(mk(1,0,1,0, 5,0,4'hA,0, 1,0,1, 5,4'hA, 0,0,0));
        tbl.push_back(mk(1,0,0,0, 5,0,4'hA,0, 1,0,0, 5,4'hA, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,    0,0,0, 5,4'hA, 1,0,4'hA));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 5,4'hA, 0,0,0));
        // continuous contention: grants alternate starting with port 1
        tbl.push_back(mk(1,1,0,0, 10,20,0,0, 0,1,0, 20,0, 0,0,0));
        tbl.push_back(mk(1,1,0,0, 10,20,0,0, 1,0,0, 10,0, 0,1,4'h4));
        tbl.push_back(mk(1,1,0,0, 10,20,0,0, 0,1,0, 20,0, 1,0,4'hA));
        tbl.push_back(mk(1,1,0,0, 10,20,0,0, 1,0,0, 10,0, 0,1,4'h4));
        tbl.push_back(mk(1,1,0,0, 10,20,0,0, 0,1,0, 20,0, 1,0,4'hA));
        tbl.push_back(mk(1,1,0,0, 10,20,0,0, 1,0,0, 10,0, 0,1,4'h4));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,     0,0,0, 10,0, 1,0,4'hA));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,     0,0,0, 10,0, 0,0,0));
        // back-to-back write (port 1) then read (port 0) of addr 31
        tbl.push_back(mk(0,1,0,1, 0,31,0,3, 0,1,1, 31,3, 0,0,0));
        tbl.push_back(mk(1,0,0,0, 31,0,0,0, 1,0,0, 31,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,  0,0,0, 31,0, 1,0,4'h3));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,  0,0,0, 31,0, 0,0,0));
        // port 0 withdraws; last must still point at port 1 afterwards
        tbl.push_back(mk(1,1,0,0, 7,9,0,0, 0,1,0, 9,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0, 7,9,0,0, 0,1,0, 9,0, 0,1,4'h9));
        tbl.push_back(mk(1,1,0,0, 7,9,0,0, 1,0,0, 7,0, 0,1,4'h9));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 7,0, 1,0,4'h7));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 7,0, 0,0,0));

        @(posedge clk);
        #1;
        chk("rst mem_w", -1, int'(bus.mem_w), 0);
        chk("rst mem_addr", -1, int'(bus.mem_addr), 0);
        chk("rst mem_din", -1, int'(bus.mem_din), 0);
        chk("rst rvalid0", -1, int'(bus.rvalid0), 0);
        chk("rst rvalid1", -1, int'(bus.rvalid1), 0);
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // reset one cycle after a port-0 read transfer
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 5;
        @(posedge clk);
        #1;
        chk("pre-rst mem_addr", 100, int'(bus.mem_addr), 5);
        bus.req0 = 0; bus.req1 = 1; bus.addr1 = 3;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid-rst mem_w", 101, int'(bus.mem_w), 0);
        chk("mid-rst mem_addr", 101, int'(bus.mem_addr), 0);
        chk("mid-rst rvalid0", 101, int'(bus.rvalid0), 0);
        chk("mid-rst rvalid1", 101, int'(bus.rvalid1), 0);
        chk("mid-rst gnt1", 101, int'(bus.gnt1), 1);
        @(posedge clk);
        #1;
        chk("held-rst mem_addr", 102, int'(bus.mem_addr), 0);
        chk("held-rst rvalid0", 102, int'(bus.rvalid0), 0);
        bus.req1 = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post-rst rvalid0", 103 + i, int'(bus.rvalid0), 0);
            chk("post-rst rvalid1", 103 + i, int'(bus.rvalid1), 0);
            chk("post-rst mem_w", 103 + i, int'(bus.mem_w), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
